fft_frame_loader: RTL and testbench
===================================

Name: fft_frame_loader

Overview:
- Upstream stage of the FFT sample RAM: collects a frame of 2^N_LOG2 real audio samples from the ADC sample strobe and writes each sample as a 32-bit complex word.
- Word format: {real[15:0], imag[15:0]}, with imag = 0.
- Write address is bit-reversed, so the in-place radix-2 FFT engine can run directly on the RAM contents.
- After the frame is complete, it hands the RAM to the FFT engine with a start pulse. It then drops incoming samples and counts them until the engine reports completion.

Parameters:
- N_LOG2, 9, log2 of frame length; RAM address width (512 points).
- IN_W, 12, width of the unsigned offset-binary ADC sample (IN_W <= 16).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- sample_in  in  IN_W  unsigned ADC sample; valid only when sample_strobe = 1.
- sample_strobe  in  1  one-cycle pulse per new sample; no backpressure.
- fft_done  in  1  one-cycle pulse from the FFT engine: transform finished, RAM released.
- ram_addr  out  N_LOG2  RAM address (bit-reversed sample index).
- ram_wdata  out  32  {real, imag} word to RAM.
- ram_we  out  1  RAM write enable, one cycle per sample.
- load_active  out  1  high while the loader owns the RAM port; top-level mux selects loader vs FFT engine on this signal.
- fft_start  out  1  one-cycle pulse: frame loaded, FFT may begin.
- drop_count  out  8  saturating count of samples dropped while not loading.

Behaviour:
- Reset (async, active-high) values: ram_addr = 0, ram_wdata = 0, ram_we = 0, fft_start = 0, drop_count = 0, load_active = 1, state = LOAD, idx = 0.
- All outputs are registered.
- States:
  - LOAD: load_active = 1. On sample_strobe, the next cycle drives:
    - ram_we = 1;
    - ram_addr = bitrev(idx), i.e. bit k of idx maps to bit N_LOG2-1-k;
    - ram_wdata = {real, 16'h0000}.
    - idx then increments.
    - The write completes when the strobe for idx = 2^N_LOG2-1 is accepted; next state is START.
  - START:
    - entered on the cycle the final write is driven (ram_we = 1, load_active = 1 that cycle);
    - next cycle: fft_start = 1 for exactly one cycle, load_active = 0, ram_we = 0; go to WAIT_FFT.
  - WAIT_FFT: load_active = 0, ram_we = 0. On fft_done: next cycle idx = 0, load_active = 1, state = LOAD.
- Sample conversion: real = {~sample_in[IN_W-1], sample_in[IN_W-2:0], (16-IN_W) zero bits}. This is offset-binary to two's complement, left-aligned. Examples for IN_W = 12:
  - 0x800 -> 0x0000
  - 0xFFF -> 0x7FF0
  - 0x000 -> 0x8000
- ram_we is low on every cycle without an accepted sample. ram_addr and ram_wdata hold their last values when ram_we = 0.
- Dropped samples:
  - sample_strobe in START or WAIT_FFT -> sample discarded, drop_count += 1, saturating at 255.
  - drop_count is cleared only by reset.
- sample_strobe on the cycle fft_done is accepted (in WAIT_FFT) -> counted as dropped; loading begins with the next strobe.
- fft_done while in LOAD or START -> ignored (no state change, no count).
- Back-to-back strobes (every cycle) are supported in LOAD, at one write per cycle.
- Reset asserted mid-frame or mid-FFT -> immediate return to reset values. The partial frame is abandoned; the next frame restarts at idx 0.
- Latency:
  - strobe -> RAM write: 1 cycle.
  - final strobe -> fft_start: 2 cycles.
  - fft_done -> ready to load: 1 cycle.

Test Plan:
- After reset, strobe 512 samples (sample_in = idx[11:0] + 0x800) -> writes seen at addr bitrev(idx), e.g. idx 1 -> addr 0x100, idx 3 -> addr 0x180, idx 511 -> addr 0x1FF; wdata[15:0] = 0 always; fft_start is a single pulse 2 cycles after strobe 511; load_active falls with it.
- Conversion: sample_in 0x800 / 0xFFF / 0x000 / 0x7FF -> ram_wdata 0x00000000 / 0x7FF00000 / 0x80000000 / 0xFFF00000.
- After fft_start, apply 300 strobes before fft_done -> no ram_we; drop_count = 255 (saturated). Pulse fft_done -> load_active = 1 next cycle; the next strobe writes to addr 0.
- Strobe on every cycle for a full frame -> 512 consecutive ram_we cycles, no drops. Strobe coincident with fft_done -> drop_count +1; that sample is not written.
- Load 100 samples, assert reset for 1 cycle mid-stream -> all outputs return to reset values immediately. The next 512 strobes produce a complete frame starting at addr 0 and exactly one fft_start.
- fft_done pulsed during LOAD at idx 200 -> ignored; the frame completes normally and fft_start fires only after sample 511.

Source files
------------

// File: rtl/fft_frame_loader.sv
// Frame loader for the FFT sample RAM: bit-reversed writes of
// converted ADC samples, then a start handoff to the FFT engine.
module fft_frame_loader #(
  parameter int N_LOG2 = 9,
  parameter int IN_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IN_W-1:0]   sample_in,
  input  logic              sample_strobe,
  input  logic              fft_done,
  output logic [N_LOG2-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic              load_active,
  output logic              fft_start,
  output logic [7:0]        drop_count
);

  typedef enum logic [1:0] {
    LOAD,
    START,
    WAIT_FFT
  } state_t;

  state_t            state;
  logic [N_LOG2-1:0] idx;
  logic [N_LOG2-1:0] idx_rev;
  logic [IN_W-1:0]   tc;
  logic [15:0]       re_val;
  logic              drop;

  always_comb begin
    idx_rev = '0;
    for (int k = 0; k < N_LOG2; k++)
      idx_rev[N_LOG2-1-k] = idx[k];
  end

  // offset-binary to two's complement, left-aligned in 16 bits
  assign tc     = {~sample_in[IN_W-1], sample_in[IN_W-2:0]};
  assign re_val = 16'(tc) << (16 - IN_W);

  assign drop = sample_strobe && (state != LOAD)
             && (drop_count != 8'hFF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= LOAD;
      idx         <= '0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_we      <= 1'b0;
      load_active <= 1'b1;
      fft_start   <= 1'b0;
      drop_count  <= '0;
    end else begin
      ram_we    <= 1'b0;
      fft_start <= 1'b0;
      if (drop)
        drop_count <= drop_count + 8'd1;
      unique case (state)
        LOAD: begin
          if (sample_strobe) begin
            ram_we    <= 1'b1;
            ram_addr  <= idx_rev;
            ram_wdata <= {re_val, 16'h0000};
            idx       <= idx + 1'b1;
            if (idx == '1)
              state <= START;
          end
        end
        START: begin
          fft_start   <= 1'b1;
          load_active <= 1'b0;
          state       <= WAIT_FFT;
        end
        WAIT_FFT: begin
          if (fft_done) begin
            idx         <= '0;
            load_active <= 1'b1;
            state       <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Self-checking bench for fft_frame_loader against a
// frame-level reference model.
module tb_fft_frame_loader;

  localparam int N  = 9;
  localparam int FR = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] sample;
  logic        strobe;
  logic        done;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic        load_active;
  logic        fft_start;
  logic [7:0]  drop_count;

  fft_frame_loader #(.N_LOG2(9), .IN_W(12)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample),
    .sample_strobe(strobe),
    .fft_done     (done),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .load_active  (load_active),
    .fft_start    (fft_start),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;

  // reference model state
  int          m_phase;
  int          m_cnt;
  logic        e_we;
  logic [8:0]  e_addr;
  logic [31:0] e_wd;
  logic        e_la;
  logic        e_start;
  logic [7:0]  e_drop;

  localparam logic [51:0] RST_VEC =
    {1'b0, 9'd0, 32'd0, 1'b1, 1'b0, 8'd0};

  function automatic int brev(input int i);
    int r = 0;
    int v = i;
    for (int k = 0; k < N; k++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  function automatic logic [31:0] conv(input int s);
    int v;
    v = (s - 2048) * 16;
    return {v[15:0], 16'h0000};
  endfunction

  function automatic logic [51:0] dut_vec();
    return {ram_we, ram_addr, ram_wdata,
            load_active, fft_start, drop_count};
  endfunction

  function automatic logic [51:0] exp_vec();
    return {e_we, e_addr, e_wd, e_la, e_start, e_drop};
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_cnt   = 0;
    e_we    = 0;
    e_addr  = '0;
    e_wd    = '0;
    e_la    = 1;
    e_start = 0;
    e_drop  = '0;
  endtask

  // phase 0: filling, 1: frame full, 2: engine busy
  task automatic model_step(input bit st, input int s,
                            input bit d);
    e_we    = 0;
    e_start = 0;
    if (st && m_phase != 0 && e_drop != 8'd255)
      e_drop = e_drop + 8'd1;
    case (m_phase)
      0: if (st) begin
        e_we   = 1;
        e_addr = 9'(brev(m_cnt));
        e_wd   = conv(s);
        m_cnt++;
        if (m_cnt == FR) m_phase = 1;
      end
      1: begin
        e_start = 1;
        e_la    = 0;
        m_phase = 2;
      end
      default: if (d) begin
        m_cnt   = 0;
        e_la    = 1;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic tick(input bit st, input logic [11:0] s,
                      input bit d);
    strobe = st;
    sample = s;
    done   = d;
    model_step(st, int'(s), d);
    @(posedge clk);
    #1;
    strobe = 0;
    done   = 0;
    cyc_n++;
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic test_reset();
    reset  = 1;
    strobe = 0;
    done   = 0;
    sample = '0;
    model_reset();
    #3;
    n_vec++;
    if (dut_vec() !== RST_VEC) begin
      n_err++;
      $display("FAIL reset_state got %h want %h",
               dut_vec(), RST_VEC);
    end
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic test_conversion();
    logic [11:0] pat [4];
    logic [31:0] want [4];
    logic [8:0]  wadr [4];
    pat  = '{12'h800, 12'hFFF, 12'h000, 12'h7FF};
    want = '{32'h0000_0000, 32'h7FF0_0000,
             32'h8000_0000, 32'hFFF0_0000};
    wadr = '{9'h000, 9'h100, 9'h080, 9'h180};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1, pat[i], 0);
      n_vec++;
      if ({ram_we, ram_addr, ram_wdata} !==
          {1'b1, wadr[i], want[i]}) begin
        n_err++;
        $display("FAIL conv_%0d got we=%b a=%h d=%h want a=%h d=%h",
                 i, ram_we, ram_addr, ram_wdata, wadr[i], want[i]);
      end
    end
  endtask

  task automatic test_full_frame();
    int last_c = -1;
    int st_c = -1;
    int starts = 0;
    do_reset();
    for (int i = 0; i < FR; i++) begin
      repeat ($urandom_range(0, 2)) begin
        tick(0, 12'($urandom), 0);
        n_vec++;
        if (dut_vec() !== exp_vec()) begin
          n_err++;
          $display("FAIL frame_idle got %h want %h",
                   dut_vec(), exp_vec());
        end
      end
      tick(1, 12'(i + 12'h800), 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL frame_wr_%0d got %h want %h",
                 i, dut_vec(), exp_vec());
      end
      if (i == 1 || i == 3 || i == 511) begin
        n_vec++;
        if (ram_addr !== 9'(brev(i)) || ram_wdata[15:0] !== 16'h0) begin
          n_err++;
          $display("FAIL frame_addr_%0d got %h", i, ram_addr);
        end
      end
    end
    last_c = cyc_n;
    for (int j = 0; j < 4; j++) begin
      tick(0, 12'h0, 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL frame_tail got %h want %h",
                 dut_vec(), exp_vec());
      end
      if (fft_start === 1'b1) begin
        starts++;
        st_c = cyc_n;
      end
    end
    n_vec++;
    if (starts != 1 || st_c != last_c + 1) begin
      n_err++;
      $display("FAIL start_pulse got n=%0d at %0d want 1 at %0d",
               starts, st_c, last_c + 1);
    end
  endtask

  task automatic test_drop_saturate();
    int wes = 0;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 1)) tick(0, 12'h0, 0);
      tick(1, 12'($urandom), 0);
      if (ram_we === 1'b1) wes++;
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL drop_%0d got %h want %h",
                 i, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if (drop_count !== 8'd255 || wes != 0) begin
      n_err++;
      $display("FAIL drop_sat got cnt=%0d we=%0d want 255 0",
               drop_count, wes);
    end
    tick(0, 12'h0, 1);
    n_vec++;
    if (load_active !== 1'b1 || dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL done_reload got %h want %h",
               dut_vec(), exp_vec());
    end
    tick(1, 12'h123, 0);
    n_vec++;
    if ({ram_we, ram_addr} !== {1'b1, 9'h000}
        || dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL reload_addr got %h want %h",
               dut_vec(), exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    int wes = 0;
    do_reset();
    for (int i = 0; i < FR; i++) begin
      tick(1, 12'($urandom), 0);
      if (ram_we === 1'b1) wes++;
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL b2b_%0d got %h want %h",
                 i, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if (wes != FR || drop_count !== 8'd0) begin
      n_err++;
      $display("FAIL b2b_count got we=%0d drop=%0d want 512 0",
               wes, drop_count);
    end
    repeat (3) tick(0, 12'h0, 0);
    tick(1, 12'h456, 1);
    n_vec++;
    if ({ram_we, load_active, drop_count} !== {1'b0, 1'b1, 8'd1}
        || dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL strobe_with_done got %h want %h",
               dut_vec(), exp_vec());
    end
    tick(1, 12'h789, 0);
    n_vec++;
    if ({ram_we, ram_addr} !== {1'b1, 9'h000}
        || dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL after_done_wr got %h want %h",
               dut_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    int starts = 0;
    do_reset();
    for (int i = 0; i < 100; i++) tick(1, 12'($urandom), 0);
    #2;
    reset = 1;
    #1;
    n_vec++;
    if (dut_vec() !== RST_VEC) begin
      n_err++;
      $display("FAIL async_reset got %h want %h",
               dut_vec(), RST_VEC);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
    for (int i = 0; i < FR + 4; i++) begin
      tick(i < FR, 12'($urandom), 0);
      if (fft_start === 1'b1) starts++;
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL rst_frame_%0d got %h want %h",
                 i, dut_vec(), exp_vec());
      end
      if (i == 0) begin
        n_vec++;
        if ({ram_we, ram_addr} !== {1'b1, 9'h000}) begin
          n_err++;
          $display("FAIL rst_first_addr got %h want 000", ram_addr);
        end
      end
    end
    n_vec++;
    if (starts != 1) begin
      n_err++;
      $display("FAIL rst_starts got %0d want 1", starts);
    end
  endtask

  task automatic test_done_in_load();
    int starts = 0;
    int st_c = -1;
    int last_c = -1;
    do_reset();
    for (int i = 0; i < FR; i++) begin
      if (i == 200) begin
        tick(0, 12'h0, 1);
        n_vec++;
        if (dut_vec() !== exp_vec()) begin
          n_err++;
          $display("FAIL done_in_load got %h want %h",
                   dut_vec(), exp_vec());
        end
      end
      tick(1, 12'($urandom), 0);
      if (fft_start === 1'b1) starts++;
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL dil_%0d got %h want %h",
                 i, dut_vec(), exp_vec());
      end
    end
    last_c = cyc_n;
    for (int j = 0; j < 3; j++) begin
      tick(0, 12'h0, 0);
      if (fft_start === 1'b1) begin
        starts++;
        st_c = cyc_n;
      end
    end
    n_vec++;
    if (starts != 1 || st_c != last_c + 1) begin
      n_err++;
      $display("FAIL dil_start got n=%0d at %0d want 1 at %0d",
               starts, st_c, last_c + 1);
    end
  endtask

  initial begin
    test_reset();
    test_conversion();
    test_full_frame();
    test_drop_saturate();
    test_back_to_back();
    test_reset_mid();
    test_done_in_load();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
